// File: rtl/stencil_pkg.sv
// rtl/stencil_pkg.sv - shared types and constants for the 3x3 stencil stream block
package stencil_pkg;

  typedef enum logic [1:0] {
    MODE_BYPASS = 2'd0,
    MODE_GAUSS  = 2'd1,
    MODE_LAPL   = 2'd2
  } mode_e;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FLUSH,
    DONE
  } state_e;

  localparam int GAUSS_RND   = 8;
  localparam int GAUSS_SHIFT = 4;

  // Reserved encoding 3 falls back to bypass.
  function automatic mode_e decode_mode(input logic [1:0] m);
    case (m)
      2'd1:    return MODE_GAUSS;
      2'd2:    return MODE_LAPL;
      default: return MODE_BYPASS;
    endcase
  endfunction

endpackage

// File: rtl/stencil_line_buffer.sv
// rtl/stencil_line_buffer.sv - one image line of storage, old contents visible while the same address is written
module stencil_line_buffer #(
  parameter int PIX_W = 8,
  parameter int DEPTH = 2048,
  parameter int AW    = 11
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    addr,
  input  logic [PIX_W-1:0] wdata,
  output logic [PIX_W-1:0] rdata
);

  logic [PIX_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/stencil_stream_top.sv
// rtl/stencil_stream_top.sv - streaming 3x3 stencil (bypass / gaussian / laplacian) over one raster frame
// Optional STENCIL_BORDER_REPLICATE_EN: filter border pixels with clamped neighbours instead of passing them through.
module stencil_stream_top
  import stencil_pkg::*;
#(
  parameter int PIX_W = 8,
  parameter int DIM_W = 12,
  parameter int MAX_X = 2048
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       mode,
  input  logic [DIM_W-1:0] size_x,
  input  logic [DIM_W-1:0] size_y,
  input  logic [PIX_W-1:0] in_pixel,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [PIX_W-1:0] out_pixel,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_eol,
  output logic             out_eof,
  output logic             busy,
  output logic             cfg_err
);

  localparam int AW      = $clog2(MAX_X);
  localparam int GW      = PIX_W + 4;
  localparam int LW      = PIX_W + 5;
  localparam int PIX_MAX = (1 << PIX_W) - 1;

  state_e           state, state_next;
  mode_e            mode_q;
  logic [DIM_W-1:0] sx_q, sy_q;
  logic [DIM_W-1:0] x;
  logic [DIM_W:0]   y;
  logic [DIM_W-1:0] ox, oy;
  logic [2:0][1:0][PIX_W-1:0] win;
  logic [PIX_W-1:0] lb0_rd, lb1_rd, in_eff, filt;
  logic             cfg_ok, adv, emit, last_in, accept_start;
  logic             at_left, at_right, at_top, at_bot;

  assign cfg_ok = (size_x >= DIM_W'(3)) && ({1'b0, size_x} <= (DIM_W+1)'(MAX_X))
                  && (size_y >= DIM_W'(2));
  assign accept_start = (state == IDLE) && start && cfg_ok;

  assign in_ready = (state == RUN) && (!out_valid || out_ready);
  assign adv = (!out_valid || out_ready)
               && (((state == RUN) && in_valid) || ((state == FLUSH) && !(out_valid && out_eof)));
  assign busy   = (state == RUN) || (state == FLUSH);
  assign in_eff = (state == RUN) ? in_pixel : '0;

  assign last_in = (x == sx_q - DIM_W'(1)) && (y == {1'b0, sy_q} - (DIM_W+1)'(1));
  // First output appears once a full line plus two pixels has been shifted in.
  assign emit = (y != '0) && !((y == (DIM_W+1)'(1)) && (x == '0));

  assign at_left  = (ox == '0);
  assign at_right = (ox == sx_q - DIM_W'(1));
  assign at_top   = (oy == '0);
  assign at_bot   = (oy == sy_q - DIM_W'(1));

  stencil_line_buffer #(.PIX_W(PIX_W), .DEPTH(MAX_X), .AW(AW)) u_lb0 (
    .clk(clk), .we(adv), .addr(x[AW-1:0]), .wdata(in_eff), .rdata(lb0_rd)
  );

  stencil_line_buffer #(.PIX_W(PIX_W), .DEPTH(MAX_X), .AW(AW)) u_lb1 (
    .clk(clk), .we(adv), .addr(x[AW-1:0]), .wdata(lb0_rd), .rdata(lb1_rd)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept_start) state_next = RUN;
      RUN:     if (adv && last_in) state_next = FLUSH;
      FLUSH:   if (out_valid && out_eof && out_ready) state_next = DONE;
      default: state_next = IDLE;
    endcase
  end

  // The incoming column (line buffers + new pixel) is the east column of the centre being emitted.
  always_comb begin
    logic [PIX_W-1:0] t_l, t_c, t_r, m_l, m_c, m_r, b_l, b_c, b_r;
    logic [GW-1:0]    gsum;
    logic [LW-1:0]    lsum, lmag;
    logic [PIX_W-1:0] gauss_pix, lap_pix;
    t_l = win[0][0]; t_c = win[0][1]; t_r = lb1_rd;
    m_l = win[1][0]; m_c = win[1][1]; m_r = lb0_rd;
    b_l = win[2][0]; b_c = win[2][1]; b_r = in_eff;
`ifdef STENCIL_BORDER_REPLICATE_EN
    if (at_left)  begin t_l = t_c; m_l = m_c; b_l = b_c; end
    if (at_right) begin t_r = t_c; m_r = m_c; b_r = b_c; end
    if (at_top)   begin t_l = m_l; t_c = m_c; t_r = m_r; end
    if (at_bot)   begin b_l = m_l; b_c = m_c; b_r = m_r; end
`endif
    gsum = (GW'(m_c) << 2) + ((GW'(t_c) + GW'(b_c) + GW'(m_l) + GW'(m_r)) << 1)
           + GW'(t_l) + GW'(t_r) + GW'(b_l) + GW'(b_r) + GW'(GAUSS_RND);
    gauss_pix = gsum[GAUSS_SHIFT +: PIX_W];
    lsum = (LW'(m_c) << 3) - LW'(t_l) - LW'(t_c) - LW'(t_r) - LW'(m_l)
           - LW'(m_r) - LW'(b_l) - LW'(b_c) - LW'(b_r);
    lmag = lsum[LW-1] ? (~lsum + LW'(1)) : lsum;
    lap_pix = (lmag > LW'(PIX_MAX)) ? '1 : lmag[PIX_W-1:0];
    case (mode_q)
      MODE_GAUSS: filt = gauss_pix;
      MODE_LAPL:  filt = lap_pix;
      default:    filt = m_c;
    endcase
`ifndef STENCIL_BORDER_REPLICATE_EN
    if (at_left || at_right || at_top || at_bot) filt = m_c;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mode_q    <= MODE_BYPASS;
      sx_q      <= '0;
      sy_q      <= '0;
      x         <= '0;
      y         <= '0;
      ox        <= '0;
      oy        <= '0;
      win       <= '0;
      out_valid <= 1'b0;
      out_pixel <= '0;
      out_eol   <= 1'b0;
      out_eof   <= 1'b0;
      cfg_err   <= 1'b0;
    end else begin
      cfg_err <= (state == IDLE) && start && !cfg_ok;
      if (accept_start) begin
        mode_q <= decode_mode(mode);
        sx_q   <= size_x;
        sy_q   <= size_y;
        x      <= '0;
        y      <= '0;
        ox     <= '0;
        oy     <= '0;
      end
      if (adv) begin
        if (x == sx_q - DIM_W'(1)) begin
          x <= '0;
          y <= y + (DIM_W+1)'(1);
        end else begin
          x <= x + DIM_W'(1);
        end
        for (int r = 0; r < 3; r++) win[r][0] <= win[r][1];
        win[0][1] <= lb1_rd;
        win[1][1] <= lb0_rd;
        win[2][1] <= in_eff;
      end
      if (adv && emit) begin
        out_valid <= 1'b1;
        out_pixel <= filt;
        out_eol   <= at_right;
        out_eof   <= at_right && at_bot;
        if (at_right) begin
          ox <= '0;
          oy <= oy + DIM_W'(1);
        end else begin
          ox <= ox + DIM_W'(1);
        end
      end else if (out_ready) begin
        out_valid <= 1'b0;
        out_eol   <= 1'b0;
        out_eof   <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_stencil_stream_top.sv
// tb/tb_stencil_stream_top.sv - self-checking bench for stencil_stream_top
module tb_stencil_stream_top;

  localparam int PIX_W = 8;
  localparam int DIM_W = 12;
  localparam int MAX_X = 2048;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [1:0]       mode;
  logic [DIM_W-1:0] size_x, size_y;
  logic [PIX_W-1:0] in_pixel;
  logic             in_valid;
  logic             in_ready;
  logic [PIX_W-1:0] out_pixel;
  logic             out_valid;
  logic             out_ready = 1'b1;
  logic             out_eol, out_eof, busy, cfg_err;

  always #5 clk = ~clk;

  stencil_stream_top #(.PIX_W(PIX_W), .DIM_W(DIM_W), .MAX_X(MAX_X)) dut (
    .clk(clk), .rst(rst), .start(start), .mode(mode), .size_x(size_x), .size_y(size_y),
    .in_pixel(in_pixel), .in_valid(in_valid), .in_ready(in_ready),
    .out_pixel(out_pixel), .out_valid(out_valid), .out_ready(out_ready),
    .out_eol(out_eol), .out_eof(out_eof), .busy(busy), .cfg_err(cfg_err)
  );

  typedef struct {int pix; bit eol; bit eof;} exp_t;

  int   tests = 0;
  int   fails = 0;
  int   img [0:255];
  int   got [0:255];
  int   n_got;
  int   fx, fy, fm;
  exp_t expq [$];
  exp_t e;
  bit   bp_en = 1'b0;
  bit   prev_stall = 1'b0;
  int   prev_pix;

  task automatic check(input string name, input int act, input int req);
    tests++;
    if (act != req) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  function automatic int pix_at(input int x, input int y);
    int cx, cy;
    cx = (x < 0) ? 0 : ((x > fx - 1) ? fx - 1 : x);
    cy = (y < 0) ? 0 : ((y > fy - 1) ? fy - 1 : y);
    return img[cy * fx + cx];
  endfunction

  function automatic int model_pix(input int cx, input int cy);
    int m, c, s, wgt;
    m = (fm == 3) ? 0 : fm;
    c = pix_at(cx, cy);
`ifndef STENCIL_BORDER_REPLICATE_EN
    if (cx == 0 || cx == fx - 1 || cy == 0 || cy == fy - 1) return c;
`endif
    if (m == 0) return c;
    s = 0;
    for (int dy = -1; dy <= 1; dy++) begin
      for (int dx = -1; dx <= 1; dx++) begin
        if (m == 1) begin
          wgt = ((dx == 0) ? 2 : 1) * ((dy == 0) ? 2 : 1);
          s += wgt * pix_at(cx + dx, cy + dy);
        end else if (dx == 0 && dy == 0) begin
          s += 8 * c;
        end else begin
          s -= pix_at(cx + dx, cy + dy);
        end
      end
    end
    if (m == 1) return (s + 8) / 16;
    if (s < 0) s = -s;
    return (s > 255) ? 255 : s;
  endfunction

  always @(posedge clk) begin
    #1;
    out_ready = bp_en ? ($urandom_range(0, 1) == 1) : 1'b1;
  end

  always @(negedge clk) begin
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("hold_valid", int'(out_valid), 1);
        check("hold_pixel", int'(out_pixel), prev_pix);
      end
      if (out_valid && !out_ready) check("in_ready_stall", int'(in_ready), 0);
      if (out_valid && out_ready) begin
        if (expq.size() == 0) begin
          check("extra_output", expq.size(), 1);
        end else begin
          e = expq.pop_front();
          check("out_pixel", int'(out_pixel), e.pix);
          check("out_eol", int'(out_eol), int'(e.eol));
          check("out_eof", int'(out_eof), int'(e.eof));
          if (n_got < 256) got[n_got] = int'(out_pixel);
          n_got++;
        end
      end
      prev_stall = out_valid && !out_ready;
      prev_pix   = int'(out_pixel);
    end
  end

  task automatic run_frame(input int sx, input int sy, input int md, input bit bp,
                           input int abort_after, input bit poke_start);
    int  i, cyc;
    bit  acc;
    fx = sx; fy = sy; fm = md;
    expq.delete();
    for (int cy = 0; cy < sy; cy++)
      for (int cx = 0; cx < sx; cx++)
        expq.push_back('{model_pix(cx, cy), cx == sx - 1, (cx == sx - 1) && (cy == sy - 1)});
    n_got = 0;
    bp_en = bp;
    @(posedge clk); #1;
    size_x = DIM_W'(sx); size_y = DIM_W'(sy); mode = 2'(md); start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("busy_after_start", int'(busy), 1);
    i = 0; cyc = 0;
    while (i < sx * sy && cyc < 20000) begin
      in_valid = bp ? ($urandom_range(0, 3) != 0) : 1'b1;
      in_pixel = PIX_W'(img[i]);
      if (poke_start && i == sx) begin
        start = 1'b1; mode = 2'(md ^ 1); size_x = DIM_W'(2);
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      acc = in_valid && in_ready;
      @(posedge clk); #1;
      cyc++;
      if (acc) i++;
      if (abort_after >= 0 && i == abort_after) break;
    end
    in_valid = 1'b0;
    start = 1'b0;
    if (abort_after >= 0) begin
      rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      check("abort_out_valid", int'(out_valid), 0);
      check("abort_busy", int'(busy), 0);
      @(posedge clk); #1;
      rst = 1'b0;
      expq.delete();
      bp_en = 1'b0;
      return;
    end
    check("feed_count", i, sx * sy);
    cyc = 0;
    while (busy && cyc < 20000) begin
      @(posedge clk); #1;
      cyc++;
    end
    check("busy_fell", int'(busy), 0);
    check("no_valid_after", int'(out_valid), 0);
    check("outputs_left", expq.size(), 0);
    check("output_count", n_got, sx * sy);
    bp_en = 1'b0;
  endtask

  task automatic bad_start(input int sx, input int sy, input string name);
    @(posedge clk); #1;
    size_x = DIM_W'(sx); size_y = DIM_W'(sy); mode = 2'd1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check({name, "_cfg_err"}, int'(cfg_err), 1);
    check({name, "_busy"}, int'(busy), 0);
    @(posedge clk); #1;
    check({name, "_cfg_err_pulse"}, int'(cfg_err), 0);
    check({name, "_busy_idle"}, int'(busy), 0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; mode = 2'd0; size_x = '0; size_y = '0;
    in_pixel = '0; in_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_cfg_err", int'(cfg_err), 0);
    check("rst_in_ready", int'(in_ready), 0);
    check("rst_out_eol", int'(out_eol), 0);
    check("rst_out_eof", int'(out_eof), 0);
    @(posedge clk); #1;
    rst = 1'b0;

    for (int k = 0; k < 12; k++) img[k] = k;
    run_frame(4, 3, 0, 1'b0, -1, 1'b0);
    for (int k = 0; k < 12; k++) check("ramp_bypass", got[k], k);

    for (int k = 0; k < 25; k++) img[k] = 100;
    img[12] = 200;
    run_frame(5, 5, 1, 1'b0, -1, 1'b0);
    check("gauss_centre", got[12], 125);
    check("gauss_1_1", got[6], 106);
    check("gauss_1_2", got[11], 113);
    check("gauss_corner", got[0], 100);
    check("gauss_edge", got[2], 100);

    run_frame(5, 5, 2, 1'b0, -1, 1'b0);
    check("lapl_centre_sat", got[12], 255);
    check("lapl_1_2", got[11], 100);
    check("lapl_1_1", got[6], 100);

    for (int k = 0; k < 9; k++) img[k] = 0;
    img[4] = 255;
    run_frame(3, 3, 2, 1'b0, -1, 1'b0);
    check("lapl_sat_3x3", got[4], 255);

    for (int k = 0; k < 24; k++) img[k] = 50;
    run_frame(6, 4, 2, 1'b1, -1, 1'b0);
    check("lapl_flat_interior", got[7], 0);

    for (int k = 0; k < 35; k++) img[k] = int'($urandom_range(0, 255));
    run_frame(7, 5, 1, 1'b1, -1, 1'b1);

    for (int k = 0; k < 8; k++) img[k] = 200 - k;
    run_frame(4, 2, 3, 1'b0, -1, 1'b0);
    check("mode3_first", got[0], 200);

    bad_start(2, 3, "sx2");
    bad_start(5, 1, "sy1");
    bad_start(MAX_X + 1, 3, "sx_over");

    for (int k = 0; k < 24; k++) img[k] = int'($urandom_range(0, 255));
    run_frame(6, 4, 2, 1'b0, 10, 1'b0);
    for (int k = 0; k < 15; k++) img[k] = int'($urandom_range(0, 255));
    run_frame(5, 3, 1, 1'b1, -1, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
